dynamic_pointer_bank: RTL and testbench

//  Bank of NPTR independent address pointers, each WIDTH bits, replacing the

---
 rtl/dynamic_pointer_bank.sv | 144 ++++++++++++++
 tb/tb_dynamic_pointer_bank.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dynamic_pointer_bank.sv
// dynamic_pointer_bank: bank of NPTR independent WIDTH-bit address pointers.
// One update port (load / increment / decrement by a zero-extended step) and a
// registered read port with a 1-cycle valid pulse. Each pointer keeps a sticky
// overflow flag that is set on carry-out or borrow and cleared only by reset or
// by a load of that pointer.
// Optional feature macro: DP_POSTINC_EN -- a read also post-increments the read
// pointer by step, unless the update port touches the same pointer that cycle.
module dynamic_pointer_bank #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned NPTR   = 4,
    parameter int unsigned STEP_W = 4,
    localparam int unsigned SEL_W = $clog2(NPTR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic              writesig,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic              readsig,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    output logic              ovf
);

    // Pointer storage and per-pointer sticky overflow flags
    logic [WIDTH-1:0] ptr_q [NPTR];
    logic [WIDTH-1:0] ptr_d [NPTR];
    logic [NPTR-1:0]  flag_q;
    logic [NPTR-1:0]  flag_d;

    // Read port registers
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic             rd_valid_q;
    logic             rd_valid_d;
    logic             ovf_q;
    logic             ovf_d;

    // Update-port arithmetic, one bit wider to expose carry / borrow
    logic [WIDTH-1:0] step_ext;
    logic [WIDTH-1:0] wr_cur;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_diff;
    logic             upd_any;

    assign step_ext = WIDTH'(step);
    assign wr_cur   = ptr_q[wr_sel];
    assign inc_sum  = {1'b0, wr_cur} + {1'b0, step_ext};
    assign dec_diff = {1'b0, wr_cur} - {1'b0, step_ext};
    // Any update-port request, including the inc&dec no-op, claims the pointer
    assign upd_any  = writesig | inc | dec;

`ifdef DP_POSTINC_EN
    logic [WIDTH-1:0] rd_cur;
    logic [WIDTH:0]   post_sum;
    logic             post_en;

    assign rd_cur   = ptr_q[rd_sel];
    assign post_sum = {1'b0, rd_cur} + {1'b0, step_ext};
    // Update port wins over the post-increment when both target one pointer
    assign post_en  = readsig & ~(upd_any & (wr_sel == rd_sel));
`endif

    // Next-state of the pointer bank: load > (inc xor dec), plus post-increment
    always_comb begin
        for (int i = 0; i < NPTR; i++) begin
            ptr_d[i] = ptr_q[i];
        end
        flag_d = flag_q;

        if (writesig) begin
            ptr_d[wr_sel]  = data_in;
            flag_d[wr_sel] = 1'b0;
        end else if (inc && !dec) begin
            ptr_d[wr_sel] = inc_sum[WIDTH-1:0];
            if (inc_sum[WIDTH]) begin
                flag_d[wr_sel] = 1'b1;
            end
        end else if (dec && !inc) begin
            ptr_d[wr_sel] = dec_diff[WIDTH-1:0];
            if (dec_diff[WIDTH]) begin
                flag_d[wr_sel] = 1'b1;
            end
        end

`ifdef DP_POSTINC_EN
        // post_en excludes the write pointer, so this never collides with above
        if (post_en) begin
            ptr_d[rd_sel] = post_sum[WIDTH-1:0];
            if (post_sum[WIDTH]) begin
                flag_d[rd_sel] = 1'b1;
            end
        end
`endif
    end

    // Next-state of the read port: sample pre-update pointer and flag
    always_comb begin
        data_out_d = data_out_q;
        ovf_d      = ovf_q;
        rd_valid_d = readsig;
        if (readsig) begin
            data_out_d = ptr_q[rd_sel];
            ovf_d      = flag_q[rd_sel];
        end
    end

    // Pointer bank state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPTR; i++) begin
                ptr_q[i] <= '0;
            end
            flag_q <= '0;
        end else begin
            for (int i = 0; i < NPTR; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
            flag_q <= flag_d;
        end
    end

    // Read port state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_dynamic_pointer_bank.sv
// Self-checking bench for dynamic_pointer_bank: directed scenarios plus
// randomized traffic, all compared against an arithmetic reference model.
// Honors DP_POSTINC_EN the same way as the design.
module tb_dynamic_pointer_bank;

    localparam int unsigned WIDTH  = 20;
    localparam int unsigned NPTR   = 4;
    localparam int unsigned STEP_W = 4;
    localparam longint      MODV   = 64'd1 << WIDTH;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        wr_sel;
    logic              writesig;
    logic              inc;
    logic              dec;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  data_in;
    logic [1:0]        rd_sel;
    logic              readsig;
    logic [WIDTH-1:0]  data_out;
    logic              rd_valid;
    logic              ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    longint m_ptr [NPTR];
    bit     m_flag [NPTR];
    longint m_dout;
    bit     m_ovf;
    bit     m_valid;

    dynamic_pointer_bank #(
        .WIDTH (WIDTH),
        .NPTR  (NPTR),
        .STEP_W(STEP_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_sel  (wr_sel),
        .writesig(writesig),
        .inc     (inc),
        .dec     (dec),
        .step    (step),
        .data_in (data_in),
        .rd_sel  (rd_sel),
        .readsig (readsig),
        .data_out(data_out),
        .rd_valid(rd_valid),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NPTR; i++) begin
            m_ptr[i]  = 0;
            m_flag[i] = 0;
        end
        m_dout  = 0;
        m_ovf   = 0;
        m_valid = 0;
    endtask

    task automatic model_add(input int idx, input longint amt);
        longint v;
        v = m_ptr[idx] + amt;
        if (v >= MODV) begin
            v         = v - MODV;
            m_flag[idx] = 1;
        end
        m_ptr[idx] = v;
    endtask

    task automatic model_sub(input int idx, input longint amt);
        longint v;
        v = m_ptr[idx] - amt;
        if (v < 0) begin
            v         = v + MODV;
            m_flag[idx] = 1;
        end
        m_ptr[idx] = v;
    endtask

    // Apply one clock edge to the model using the currently driven inputs
    task automatic model_edge();
        bit hit;
        m_valid = readsig;
        if (readsig) begin
            m_dout = m_ptr[rd_sel];
            m_ovf  = m_flag[rd_sel];
        end
        hit = (writesig || inc || dec) && (wr_sel == rd_sel);
        if (writesig) begin
            m_ptr[wr_sel]  = longint'(data_in);
            m_flag[wr_sel] = 0;
        end else if (inc && !dec) begin
            model_add(int'(wr_sel), longint'(step));
        end else if (dec && !inc) begin
            model_sub(int'(wr_sel), longint'(step));
        end
`ifdef DP_POSTINC_EN
        if (readsig && !hit) begin
            model_add(int'(rd_sel), longint'(step));
        end
`else
        if (hit) m_valid = m_valid;
`endif
    endtask

    task automatic drive(input bit ws, input bit i_inc, input bit i_dec, input int wsel,
                         input int stp, input longint din, input bit rs, input int rsel);
        writesig = ws;
        inc      = i_inc;
        dec      = i_dec;
        wr_sel   = 2'(wsel);
        step     = STEP_W'(stp);
        data_in  = WIDTH'(din);
        readsig  = rs;
        rd_sel   = 2'(rsel);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One cycle: edge, update model, compare all outputs, return to idle
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check("rd_valid", longint'(rd_valid), longint'(m_valid));
        check("data_out", longint'(data_out), m_dout);
        check("ovf", longint'(ovf), longint'(m_ovf));
        idle();
    endtask

    task automatic op(input bit ws, input bit i_inc, input bit i_dec, input int wsel,
                      input int stp, input longint din, input bit rs, input int rsel);
        drive(ws, i_inc, i_dec, wsel, stp, din, rs, rsel);
        tick();
    endtask

    // Side-effect-free read (step 0) with explicit expected value
    task automatic read_exp(input string tag, input int idx, input longint exp_val,
                            input bit exp_ovf);
        op(0, 0, 0, 0, 0, 0, 1, idx);
        check({tag, "_val"}, longint'(data_out), exp_val);
        check({tag, "_ovf"}, longint'(ovf), longint'(exp_ovf));
        check({tag, "_vld"}, longint'(rd_valid), 1);
    endtask

    initial begin
        longint p3_exp [3];
        idle();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        check("rst_dout", longint'(data_out), 0);
        check("rst_valid", longint'(rd_valid), 0);

        // 1: reset mid-run with pointers loaded
        for (int i = 0; i < NPTR; i++) begin
            op(1, 0, 0, i, 0, longint'($urandom_range(1, 32'hFFFFF)), 0, 0);
        end
        op(0, 1, 0, 1, 15, 0, 1, 2);
        drive(0, 1, 0, 0, 7, 0, 1, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check("t1_dout", longint'(data_out), 0);
        check("t1_ovf", longint'(ovf), 0);
        check("t1_valid", longint'(rd_valid), 0);
        idle();
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < NPTR; i++) begin
            read_exp("t1_rb", i, 0, 0);
        end

        // 2: load, increment, read; other pointers untouched
        op(1, 0, 0, 2, 0, 'h00010, 0, 0);
        op(0, 1, 0, 2, 3, 0, 0, 0);
        read_exp("t2_p2", 2, 'h00013, 0);
        tick();
        check("t2_pulse", longint'(rd_valid), 0);
        check("t2_hold", longint'(data_out), 'h00013);
        read_exp("t2_p0", 0, 0, 0);
        read_exp("t2_p1", 1, 0, 0);
        read_exp("t2_p3", 3, 0, 0);

        // 3: wrap on increment sets flag, flag stays through decrement borrow
        op(1, 0, 0, 1, 0, 'hFFFFE, 0, 0);
        op(0, 1, 0, 1, 5, 0, 0, 0);
        read_exp("t3_inc", 1, 'h00003, 1);
        op(0, 0, 1, 1, 4, 0, 0, 0);
        read_exp("t3_dec", 1, 'hFFFFF, 1);
        op(1, 0, 0, 1, 0, 0, 0, 0);
        read_exp("t3_clr", 1, 0, 0);

        // 4: read-before-write, load beats inc, inc&dec is a no-op
        op(1, 0, 0, 0, 0, 'h00100, 0, 0);
        op(1, 1, 0, 0, 3, 'h00200, 1, 0);
        check("t4_rbw", longint'(data_out), 'h00100);
        read_exp("t4_new", 0, 'h00200, 0);
        op(0, 1, 1, 0, 7, 0, 0, 0);
        read_exp("t4_noop", 0, 'h00200, 0);

        // 5: post-increment on read (or pure reads without the feature)
`ifdef DP_POSTINC_EN
        p3_exp = '{'h40, 'h42, 'h44};
`else
        p3_exp = '{'h40, 'h40, 'h40};
`endif
        op(1, 0, 0, 3, 0, 'h00040, 0, 0);
        for (int k = 0; k < 3; k++) begin
            op(0, 0, 0, 0, 2, 0, 1, 3);
            check("t5_rd", longint'(data_out), p3_exp[k]);
        end
        op(0, 1, 0, 3, 2, 0, 1, 3);
        op(0, 0, 0, 0, 0, 0, 1, 3);
`ifdef DP_POSTINC_EN
        check("t5_once", longint'(data_out), 'h48);
`else
        check("t5_once", longint'(data_out), 'h42);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            drive(r == 0, r inside {[1:4], 8}, r inside {[5:8]},
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  (r == 0 && $urandom_range(0, 1) == 1) ?
                      longint'(32'hFFFF0 + $urandom_range(0, 15)) :
                      longint'($urandom_range(0, 32'hFFFFF)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
            tick();
        end
        for (int i = 0; i < NPTR; i++) begin
            read_exp("final", i, m_ptr[i], m_flag[i]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
